fpu_mem_responder: RTL and testbench
====================================

Name: fpu_mem_responder

Overview:
- Synthesizable 16-bit memory-bus responder (target side) for the FPU memory interface's word-serial initiator.
- Answers each bus access with a single-cycle registered ack after a programmable wait-state count.
- Backs the bus with an internal word array.
- Used as the FPU-side scratch/test memory and as the bus model for FPU load/store bring-up.

Parameters:
- ADDR_WIDTH, 10, word-index bits; the array holds 2^ADDR_WIDTH 16-bit words (byte window 0 .. 2^(ADDR_WIDTH+1)-1).
- WAIT_STATES, 2, cycles inserted between request capture and ack (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  in  20  byte address (wired to initiator mem_addr)
- bus_wdata  in  16  write data (initiator mem_data_out)
- bus_rdata  out  16  read data, valid while bus_ack=1 (initiator mem_data_in)
- bus_access  in  1  request; held high by the initiator across multi-word transfers
- bus_wr_en  in  1  1=write, 0=read
- bus_bytesel  in  2  00=both bytes, 01=low only, 10=high only, 11=no lanes
- bus_ack  out  1  one-cycle completion pulse
- err_range  out  1  sticky: an access fell outside the array window
- err_misalign  out  1  sticky: an access had bus_addr[0]=1
- ack_count  out  16  number of acks since reset; wraps FFFF->0000

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asynchronous, immediate): state=IDLE, bus_ack=0, bus_rdata=0000, err_range=0, err_misalign=0, ack_count=0. Array contents are not reset.
- Reset mid-operation: the pending request is discarded and no write occurs.
- IDLE:
  - On a clock edge with bus_access=1, capture addr, wdata, wr_en and bytesel.
  - Go to WAIT if WAIT_STATES>0; otherwise go to ACK.
- WAIT:
  - A counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - At the edge where the counter is 0, go to ACK.
  - If bus_access=0 at any edge in WAIT: abort to IDLE, no ack, no write, ack_count unchanged.
- Entry edge into ACK:
  - Write commits at this edge. Enabled lanes only: 00 -> [15:0], 01 -> [7:0], 10 -> [15:8], 11 -> no write (ack still given).
  - Read loads bus_rdata from the array at this edge; bytesel is ignored for reads.
  - ack_count increments at this edge.
- ACK: bus_ack=1 for exactly one cycle, then go to RECOVER.
- RECOVER:
  - One cycle with bus_ack=0, then IDLE.
  - bus_access is ignored in RECOVER. The initiator re-registers its address/data one cycle after it sees ack, so the next word becomes valid only in the following cycle.
- Latency: bus_ack is high in cycle N+WAIT_STATES+1, where N is the edge that captured the request.
- Throughput: a held bus_access yields one word per WAIT_STATES+3 cycles.
- Addressing:
  - Word index = captured addr[ADDR_WIDTH:1]; addr[0] is ignored for indexing.
  - addr[0]=1 sets err_misalign.
- Out of range (any captured addr bit above ADDR_WIDTH set):
  - Full handshake timing is kept.
  - The write is suppressed.
  - Read returns FFFF.
  - err_range is set.
- Sticky errors clear only on reset.
- bus_rdata holds its last value outside ACK.
- bus_ack never asserts without a captured request.

Test Plan:
- Word read, WAIT_STATES=2, array[0x010]=BEEF: access at 0x00020 captured at edge N -> bus_ack high only in cycle N+3 with bus_rdata=BEEF; a RECOVER cycle follows.
- TBYTE write burst at 0x00100 with data 0x4000_C90F_DAA2_2168_C235 (5 words), then a 5-word read back -> exactly 5 acks each way; words returned in order C235, 2168, DAA2, C90F, 4000; ack_count=10.
- Byte lanes: word 0x00040 preset to 1234; write bytesel=01 data AB / bytesel=10 data CD00 / bytesel=11 data FFFF -> reads return 12AB, then CDAB, then CDAB.
- Range/misalign with ADDR_WIDTH=10:
  - Read 0x00800 -> acked, FFFF, err_range=1.
  - Write 0x00803 -> acked, no array change, err_misalign=1.
- Abort: drop bus_access during the second WAIT cycle -> no ack, target word unchanged, ack_count unchanged; the next request is handled normally.
- Reset mid-WAIT with a pending write of 5555 to 0x00060 (old value 0000) -> bus_ack=0 at once; word stays 0000; flags and counter are 0 after reset.

Source files
------------

// File: rtl/fpu_mem_responder_if.sv
// fpu_mem_responder_if
//   Word-serial memory bus between the FPU memory initiator and a target.
//   master modport: initiator side (drives address, data, access, direction, lanes)
//   slave modport : target side (returns read data and the completion ack)
// Signals:
//   bus_addr    [19:0] byte address
//   bus_wdata   [15:0] write data
//   bus_rdata   [15:0] read data, valid while bus_ack=1
//   bus_access         request, held across multi-word transfers
//   bus_wr_en          1=write, 0=read
//   bus_bytesel [1:0]  00=both bytes, 01=low only, 10=high only, 11=no lanes
//   bus_ack            one-cycle completion pulse
interface fpu_mem_responder_if;
    logic [19:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_access;
    logic        bus_wr_en;
    logic [1:0]  bus_bytesel;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_access, bus_wr_en, bus_bytesel,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_access, bus_wr_en, bus_bytesel,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/fpu_mem_responder.sv
// fpu_mem_responder
//   16-bit memory-bus target backed by an internal word array. Each request is
//   captured, held for WAIT_STATES cycles, acknowledged with a one-cycle
//   registered ack, then followed by one recovery cycle.
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   bus          slave side of fpu_mem_responder_if
//   err_range    sticky: an access fell outside the array window
//   err_misalign sticky: an access had bus_addr[0]=1
//   ack_count    acks since reset, wraps FFFF->0000
module fpu_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    fpu_mem_responder_if.slave         bus,
    output logic                       err_range,
    output logic                       err_misalign,
    output logic [15:0]                ack_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    // Address bits above the byte window; any of them set means out of range.
    localparam logic [19:0] HI_MASK = 20'(~((32'd1 << (ADDR_WIDTH + 1)) - 32'd1));

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic [1:0]  bsel_q;
    logic        ack_q;
    logic [15:0] rdata_q, rdata_d;
    logic        err_range_q, err_range_d;
    logic        err_mis_q, err_mis_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] mem_q [DEPTH];

    logic                  capture;
    logic                  commit;
    logic [19:0]           eff_addr;
    logic [15:0]           eff_wdata;
    logic                  eff_wr;
    logic [1:0]            eff_bsel;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;

    // With zero wait states the commit happens on the capture edge itself,
    // so the live bus values are used instead of the (not yet loaded) captures.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_addr  = bus.bus_addr;
            eff_wdata = bus.bus_wdata;
            eff_wr    = bus.bus_wr_en;
            eff_bsel  = bus.bus_bytesel;
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_wr    = wr_q;
            eff_bsel  = bsel_q;
        end
    end

    assign in_range = ((eff_addr & HI_MASK) == 20'd0);
    assign idx      = eff_addr[ADDR_WIDTH:1];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.bus_access) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped request aborts even on the final wait edge.
                if (!bus.bus_access) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ACK:     state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Completion side effects, all taken on the entry edge into ACK
    always_comb begin
        rdata_d     = rdata_q;
        err_range_d = err_range_q;
        err_mis_d   = err_mis_q;
        cnt_d       = cnt_q;
        if (commit) begin
            if (!eff_wr) begin
                rdata_d = in_range ? mem_q[idx] : 16'hFFFF;
            end
            err_range_d = err_range_q | ~in_range;
            err_mis_d   = err_mis_q | eff_addr[0];
            cnt_d       = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            bsel_q      <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            err_range_q <= 1'b0;
            err_mis_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ack_q       <= commit;
            rdata_q     <= rdata_d;
            err_range_q <= err_range_d;
            err_mis_q   <= err_mis_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                addr_q  <= bus.bus_addr;
                wdata_q <= bus.bus_wdata;
                wr_q    <= bus.bus_wr_en;
                bsel_q  <= bus.bus_bytesel;
            end
        end
    end

    // Array is not reset; writes are additionally gated by reset so a request
    // seen while reset is held can never commit.
    always_ff @(posedge clk) begin
        if (commit && eff_wr && in_range && !reset) begin
            if (!eff_bsel[1]) mem_q[idx][7:0]  <= eff_wdata[7:0];
            if (!eff_bsel[0]) mem_q[idx][15:8] <= eff_wdata[15:8];
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign err_range     = err_range_q;
    assign err_misalign  = err_mis_q;
    assign ack_count     = cnt_q;

endmodule

// File: tb/tb_fpu_mem_responder.sv
// tb_fpu_mem_responder
//   Directed-vector bench for fpu_mem_responder (ADDR_WIDTH=10, WAIT_STATES=2).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_fpu_mem_responder;

    logic        clk;
    logic        reset;
    logic        err_range;
    logic        err_misalign;
    logic [15:0] ack_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    fpu_mem_responder_if bus ();

    fpu_mem_responder #(
        .ADDR_WIDTH  (10),
        .WAIT_STATES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .err_range    (err_range),
        .err_misalign (err_misalign),
        .ack_count    (ack_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus word; called on a falling edge. lat = falling edges until ack,
    // -1 if no ack arrives within the budget.
    task automatic xfer(input logic [19:0] a, input logic wr, input logic [15:0] d,
                        input logic [1:0] bs, input bit hold,
                        output logic [15:0] rd, output int lat);
        bit got;
        bus.bus_addr    = a;
        bus.bus_wdata   = d;
        bus.bus_wr_en   = wr;
        bus.bus_bytesel = bs;
        bus.bus_access  = 1'b1;
        lat = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.bus_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) lat = -1;
        else exp_cnt++;
        rd = bus.bus_rdata;
        if (!hold) bus.bus_access = 1'b0;
    endtask

    task automatic single(input string tag, input logic [19:0] a, input logic wr,
                          input logic [15:0] d, input logic [1:0] bs,
                          output logic [15:0] rd);
        int lat;
        idle(2);
        xfer(a, wr, d, bs, 1'b0, rd, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.bus_access = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] burst [5];
        int lat;
        int acks;

        burst[0] = 16'hC235; burst[1] = 16'h2168; burst[2] = 16'hDAA2;
        burst[3] = 16'hC90F; burst[4] = 16'h4000;

        reset = 1'b1;
        bus.bus_access  = 1'b0;
        bus.bus_addr    = '0;
        bus.bus_wdata   = '0;
        bus.bus_wr_en   = 1'b0;
        bus.bus_bytesel = 2'b00;
        idle(2);
        check_eq("rst_ack",   32'(bus.bus_ack), 32'd0);
        check_eq("rst_rdata", 32'(bus.bus_rdata), 32'd0);
        check_eq("rst_erng",  32'(err_range), 32'd0);
        check_eq("rst_emis",  32'(err_misalign), 32'd0);
        check_eq("rst_cnt",   32'(ack_count), 32'd0);
        reset = 1'b0;

        // Word read with two wait states
        single("wr_beef", 20'h00020, 1'b1, 16'hBEEF, 2'b00, rd);
        single("rd_beef", 20'h00020, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("rd_beef_data", 32'(rd), 32'hBEEF);
        @(negedge clk);
        check_eq("recover_ack", 32'(bus.bus_ack), 32'd0);
        check_eq("rdata_hold",  32'(bus.bus_rdata), 32'hBEEF);

        // Five-word burst write then read back
        do_reset();
        idle(1);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            xfer(20'h00100 + 20'(2 * i), 1'b1, burst[i], 2'b00, i < 4, rd, lat);
            if (lat > 0) acks++;
            check_eq("bwr_lat", 32'(lat), (i == 0) ? 32'd3 : 32'd5);
        end
        check_eq("bwr_acks", 32'(acks), 32'd5);
        idle(2);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            xfer(20'h00100 + 20'(2 * i), 1'b0, 16'h0000, 2'b00, i < 4, rd, lat);
            if (lat > 0) acks++;
            check_eq("brd_data", 32'(rd), 32'(burst[i]));
        end
        check_eq("brd_acks", 32'(acks), 32'd5);
        check_eq("burst_cnt", 32'(ack_count), 32'd10);

        // Byte lanes
        single("bl_pre", 20'h00040, 1'b1, 16'h1234, 2'b00, rd);
        single("bl_lo", 20'h00040, 1'b1, 16'h00AB, 2'b01, rd);
        single("bl_rd1", 20'h00040, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("bl_lo_data", 32'(rd), 32'h12AB);
        single("bl_hi", 20'h00040, 1'b1, 16'hCD00, 2'b10, rd);
        single("bl_rd2", 20'h00040, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("bl_hi_data", 32'(rd), 32'hCDAB);
        single("bl_none", 20'h00040, 1'b1, 16'hFFFF, 2'b11, rd);
        single("bl_rd3", 20'h00040, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("bl_none_data", 32'(rd), 32'hCDAB);

        // Range and misalignment
        single("w2_pre", 20'h00002, 1'b1, 16'h0A0A, 2'b00, rd);
        check_eq("pre_erng", 32'(err_range), 32'd0);
        single("oor_rd", 20'h00800, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("oor_data", 32'(rd), 32'hFFFF);
        check_eq("oor_erng", 32'(err_range), 32'd1);
        check_eq("oor_emis", 32'(err_misalign), 32'd0);
        single("mis_wr", 20'h00803, 1'b1, 16'h9999, 2'b00, rd);
        check_eq("mis_emis", 32'(err_misalign), 32'd1);
        single("w2_rd", 20'h00002, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("w2_unchanged", 32'(rd), 32'h0A0A);
        check_eq("cnt_mid", 32'(ack_count), 32'(exp_cnt));

        // Abort during the second wait cycle
        single("ab_pre", 20'h00080, 1'b1, 16'h1111, 2'b00, rd);
        idle(2);
        bus.bus_addr   = 20'h00080;
        bus.bus_wdata  = 16'h2222;
        bus.bus_wr_en  = 1'b1;
        bus.bus_access = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.bus_access = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.bus_ack) acks++;
        end
        check_eq("ab_noack", 32'(acks), 32'd0);
        check_eq("ab_cnt", 32'(ack_count), 32'(exp_cnt));
        single("ab_rd", 20'h00080, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("ab_data", 32'(rd), 32'h1111);

        // Reset while a write is waiting
        single("rs_pre", 20'h00060, 1'b1, 16'h0000, 2'b00, rd);
        idle(2);
        bus.bus_addr   = 20'h00060;
        bus.bus_wdata  = 16'h5555;
        bus.bus_wr_en  = 1'b1;
        bus.bus_access = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rs_ack",  32'(bus.bus_ack), 32'd0);
        check_eq("rs_erng", 32'(err_range), 32'd0);
        check_eq("rs_emis", 32'(err_misalign), 32'd0);
        check_eq("rs_cnt",  32'(ack_count), 32'd0);
        @(negedge clk);
        bus.bus_access = 1'b0;
        reset = 1'b0;
        exp_cnt = 0;
        single("rs_rd", 20'h00060, 1'b0, 16'h0000, 2'b00, rd);
        check_eq("rs_data", 32'(rd), 32'h0000);
        check_eq("rs_cnt_after", 32'(ack_count), 32'(exp_cnt));

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
